// File: rtl/tristate_pin_sequencer_if.sv
// Bus between the pin sequencer and its surroundings: two requesters on one
// side, the IOBUF (I/T/O) on the other, plus the completion report.
interface tristate_pin_sequencer_if #(
   parameter int WIDTH = 8
);
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [WIDTH-1:0] data_a;
   logic [WIDTH-1:0] data_b;
   logic             io_i;
   logic             io_t;
   logic             io_o;
   logic             done;
   logic             done_id;
   logic             err;
   logic [WIDTH-1:0] rx_data;
   logic             busy;

   // user logic + pin side
   modport master (
      output req_valid, data_a, data_b, io_o,
      input  req_ready, io_i, io_t, done, done_id, err, rx_data, busy
   );

   // the sequencer itself
   modport slave (
      input  req_valid, data_a, data_b, io_o,
      output req_ready, io_i, io_t, done, done_id, err, rx_data, busy
   );
endinterface

// File: rtl/tristate_pin_sequencer.sv
// Shares one IOBUF pin between requesters A and B. Round-robin grant, high-Z
// turnaround before each drive, MSB-first serial shift with readback check
// through a 2-flop synchronizer on the pin input.
module tristate_pin_sequencer #(
   parameter int WIDTH    = 8,
   parameter int CLK_DIV  = 4,
   parameter int TURN_CYC = 2
) (
   input logic                   clk,
   input logic                   rst_n,
   tristate_pin_sequencer_if.slave bus
);
   localparam int PH_W = $clog2(CLK_DIV);
   localparam int BT_W = $clog2(WIDTH + 1);
   localparam int TC_W = $clog2(TURN_CYC + 1);

   typedef enum logic [1:0] {IDLE, TURN, SHIFT, DONE} state_t;

   state_t           state_q;
   logic [1:0]       sync_q;
   logic             ptr_q;       // last granted requester (1 = B)
   logic             own_q;
   logic             err_acc_q;   // sticky mismatch for the running transfer
   logic [WIDTH-1:0] tx_q;
   logic [WIDTH-1:0] rx_q;
   logic [PH_W-1:0]  ph_q;
   logic [BT_W-1:0]  bit_q;
   logic [TC_W-1:0]  turn_q;

   logic [1:0]       ready_q;
   logic             io_i_q;
   logic             io_t_q;
   logic             done_q;
   logic             done_id_q;
   logic             err_q;
   logic [WIDTH-1:0] rx_data_q;

   logic [1:0]       win_d;
   logic             accept;
   logic [WIDTH-1:0] rx_d;
   logic [WIDTH-1:0] tx_d;
   logic             mis_d;

   // io_o is asynchronous to clk; only the second flop is ever used
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b00;
      else        sync_q <= {sync_q[0], bus.io_o};
   end

   // round-robin winner: on a tie the requester not granted last time wins
   always_comb begin
      win_d = 2'b00;
      case (bus.req_valid)
         2'b01:   win_d = 2'b01;
         2'b10:   win_d = 2'b10;
         2'b11:   win_d = ptr_q ? 2'b01 : 2'b10;
         default: win_d = 2'b00;
      endcase
   end

   assign accept = |(bus.req_valid & ready_q);
   assign rx_d   = WIDTH'({rx_q, sync_q[1]});
   assign tx_d   = tx_q << 1;
   assign mis_d  = sync_q[1] != io_i_q;

   // sequencer FSM; every pin-facing output is a flop so io_o never reaches them combinationally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= 1'b1;
         own_q     <= 1'b0;
         err_acc_q <= 1'b0;
         tx_q      <= '0;
         rx_q      <= '0;
         ph_q      <= '0;
         bit_q     <= '0;
         turn_q    <= '0;
         ready_q   <= 2'b00;
         io_i_q    <= 1'b0;
         io_t_q    <= 1'b1;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
         err_q     <= 1'b0;
         rx_data_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= TURN;
                  ready_q <= 2'b00;
                  own_q   <= ready_q[1];
                  ptr_q   <= ready_q[1];
                  tx_q    <= ready_q[1] ? bus.data_b : bus.data_a;
                  turn_q  <= '0;
               end else begin
                  ready_q <= win_d;
               end
            end
            TURN: begin
               if (turn_q == TC_W'(TURN_CYC - 1)) begin
                  state_q <= SHIFT;
                  io_t_q  <= 1'b0;
                  io_i_q  <= tx_q[WIDTH-1];
               end else begin
                  turn_q <= turn_q + 1'b1;
               end
            end
            SHIFT: begin
               if (ph_q == PH_W'(CLK_DIV - 1)) begin
                  ph_q      <= '0;
                  rx_q      <= rx_d;
                  err_acc_q <= err_acc_q | mis_d;
                  if (bit_q == BT_W'(WIDTH - 1)) begin
                     state_q   <= DONE;
                     io_t_q    <= 1'b1;
                     io_i_q    <= 1'b0;
                     done_q    <= 1'b1;
                     done_id_q <= own_q;
                     err_q     <= err_acc_q | mis_d;
                     rx_data_q <= rx_d;
                  end else begin
                     bit_q  <= bit_q + 1'b1;
                     tx_q   <= tx_d;
                     io_i_q <= tx_d[WIDTH-1];
                  end
               end else begin
                  ph_q <= ph_q + 1'b1;
               end
            end
            DONE: begin
               state_q   <= IDLE;
               ready_q   <= win_d;
               err_acc_q <= 1'b0;
               bit_q     <= '0;
               ph_q      <= '0;
               turn_q    <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.io_i      = io_i_q;
   assign bus.io_t      = io_t_q;
   assign bus.done      = done_q;
   assign bus.done_id   = done_id_q;
   assign bus.err       = err_q;
   assign bus.rx_data   = rx_data_q;
   assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_tristate_pin_sequencer.sv
// Bench for tristate_pin_sequencer: transaction-level model of grant, drive
// window, pin readback and completion, compared against the DUT every cycle.
module tb_tristate_pin_sequencer;
   localparam int W   = 8;
   localparam int D   = 4;
   localparam int TC  = 2;
   localparam int LEN = TC + W * D + 1;   // accept -> done distance

   logic clk = 1'b0;
   logic rst_n;
   logic force_low = 1'b0;
   always #5 clk = ~clk;

   tristate_pin_sequencer_if #(.WIDTH(W)) bus();

   // pin: loopback when driven, pulled up when released, or held low by the bench
   assign bus.io_o = force_low ? 1'b0 : (bus.io_t ? 1'b1 : bus.io_i);

   tristate_pin_sequencer #(.WIDTH(W), .CLK_DIV(D), .TURN_CYC(TC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // stimulus for the next cycle
   logic         nxt_rst = 1'b0;
   logic [1:0]   nxt_valid = 2'b00;
   logic [W-1:0] nxt_a = '0, nxt_b = '0;
   logic         nxt_force = 1'b0;
   bit           auto_drop = 1'b1;
   bit           drop_all  = 1'b0;

   // model state
   bit           m_act;
   int           m_a;
   logic [W-1:0] m_data;
   bit           m_own, m_force, m_ptr;
   logic [1:0]   m_ready;
   logic [W-1:0] m_rx;
   bit           m_err, m_id;

   // observations
   int           n_done_seen, done_cyc, acc_cyc, n_acc, tlow_cnt, hz_run, min_gap;
   bit           had_drive;
   logic [1:0]   acc_ready;
   logic [W-1:0] ioi_bits;
   logic [W-1:0] seen_rx [4];
   logic         seen_id [4];
   logic         seen_err[4];

   task automatic expect_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [1:0] winner(input logic [1:0] v, input logic last_b);
      if (v == 2'b11) return last_b ? 2'b01 : 2'b10;
      return v;
   endfunction

   task automatic model_reset();
      m_act = 0; m_ptr = 1; m_ready = 2'b00; m_rx = '0; m_err = 0; m_id = 0;
   endtask

   task automatic clear_track();
      n_done_seen = 0; tlow_cnt = 0; ioi_bits = '0; hz_run = 0; had_drive = 0; min_gap = 9999;
   endtask

   // compare DUT outputs of the current cycle against the model
   task automatic check_cycle();
      int   t;
      logic exp_t, exp_done;
      if (!rst_n) begin
         expect_eq("rst_io_t", bus.io_t, 1);
         expect_eq("rst_io_i", bus.io_i, 0);
         expect_eq("rst_ready", bus.req_ready, 0);
         expect_eq("rst_done", bus.done, 0);
         expect_eq("rst_done_id", bus.done_id, 0);
         expect_eq("rst_err", bus.err, 0);
         expect_eq("rst_rx", bus.rx_data, 0);
         expect_eq("rst_busy", bus.busy, 0);
         return;
      end
      t        = cyc - m_a;
      exp_done = m_act && (t == LEN);
      exp_t    = !(m_act && t >= TC + 1 && t <= TC + W * D);
      if (exp_done) begin
         m_rx  = m_force ? '0 : m_data;
         m_err = m_force && (m_data != '0);
         m_id  = m_own;
      end
      expect_eq("io_t", bus.io_t, exp_t);
      expect_eq("busy", bus.busy, m_act);
      expect_eq("req_ready", bus.req_ready, m_ready);
      expect_eq("done", bus.done, exp_done);
      expect_eq("rx_data", bus.rx_data, m_rx);
      if (exp_done) begin
         expect_eq("done_id", bus.done_id, m_id);
         expect_eq("err", bus.err, m_err);
      end
      if (!exp_t) expect_eq("io_i", bus.io_i, m_data[W - 1 - (t - TC - 1) / D]);
      // raw observations for the directed checks
      if (bus.done === 1'b1) begin
         if (n_done_seen < 4) begin
            seen_rx[n_done_seen]  = bus.rx_data;
            seen_id[n_done_seen]  = bus.done_id;
            seen_err[n_done_seen] = bus.err;
         end
         n_done_seen++;
         done_cyc = cyc;
      end
      if (bus.io_t === 1'b0) begin
         if (tlow_cnt % D == 0) ioi_bits = {ioi_bits[W-2:0], bus.io_i};
         tlow_cnt++;
         if (had_drive && hz_run > 0 && hz_run < min_gap) min_gap = hz_run;
         hz_run    = 0;
         had_drive = 1;
      end else if (had_drive) begin
         hz_run++;
      end
   endtask

   // one clock: check, drive, advance the model across the coming edge
   task automatic cyc_step();
      logic [1:0] v;
      @(negedge clk);
      check_cycle();
      rst_n         = nxt_rst;
      bus.req_valid = nxt_valid;
      bus.data_a    = nxt_a;
      bus.data_b    = nxt_b;
      force_low     = nxt_force;
      if (!rst_n) begin
         model_reset();
         cyc++;
         return;
      end
      v = nxt_valid;
      if (!m_act && (v & m_ready) != 2'b00) begin
         m_act = 1; m_a = cyc; m_own = m_ready[1];
         m_data = m_own ? nxt_b : nxt_a;
         m_force = nxt_force; m_ptr = m_own;
         acc_cyc = cyc; acc_ready = bus.req_ready; n_acc++;
         if (drop_all) nxt_valid = 2'b00;
         else if (auto_drop) nxt_valid[m_own] = 1'b0;
      end
      cyc++;
      if (m_act && cyc - m_a > LEN) m_act = 0;
      m_ready = m_act ? 2'b00 : winner(v, m_ptr);
   endtask

   task automatic run_until(input int target, input int budget);
      int k;
      k = 0;
      while (n_done_seen < target && k < budget) begin
         cyc_step();
         k++;
      end
      if (n_done_seen < target) expect_eq("timeout_waiting_done", n_done_seen, target);
   endtask

   task automatic do_reset();
      nxt_rst = 1'b0;
      repeat (3) begin
         nxt_valid = 2'($urandom); nxt_a = W'($urandom); nxt_b = W'($urandom);
         cyc_step();
      end
      nxt_valid = 2'b00;
      nxt_rst   = 1'b1;
      repeat (4) cyc_step();
   endtask

   initial begin
      int base;
      rst_n = 1'b1;
      bus.req_valid = 2'b00; bus.data_a = '0; bus.data_b = '0;
      model_reset();
      clear_track();
      n_acc = 0;
      #1 rst_n = 1'b0;

      // reset with random inputs, then idle
      do_reset();
      expect_eq("idle_busy", bus.busy, 0);

      // single transfer A = 0xA5 on loopback
      clear_track();
      nxt_a = 8'hA5; nxt_valid = 2'b01;
      run_until(1, 80);
      expect_eq("a5_ready_at_accept", acc_ready, 2'b01);
      expect_eq("a5_done_latency", done_cyc - acc_cyc, 35);
      expect_eq("a5_drive_cycles", tlow_cnt, 32);
      expect_eq("a5_io_i_bits", ioi_bits, 8'hA5);
      expect_eq("a5_done_id", seen_id[0], 0);
      expect_eq("a5_err", seen_err[0], 0);
      expect_eq("a5_rx", seen_rx[0], 8'hA5);

      // both valid from reset: A first, then B
      do_reset();
      clear_track();
      nxt_a = 8'h3C; nxt_b = 8'hC3; nxt_valid = 2'b11;
      run_until(2, 160);
      expect_eq("both_id0", seen_id[0], 0);
      expect_eq("both_id1", seen_id[1], 1);
      expect_eq("both_rx0", seen_rx[0], 8'h3C);
      expect_eq("both_rx1", seen_rx[1], 8'hC3);
      expect_eq("both_gap_ge4", min_gap >= 4, 1);

      // contention: pin held low
      clear_track();
      nxt_force = 1'b1; nxt_a = 8'hFF; nxt_valid = 2'b01;
      run_until(1, 80);
      expect_eq("cont_err", seen_err[0], 1);
      expect_eq("cont_rx", seen_rx[0], 8'h00);
      nxt_force = 1'b0;
      clear_track();
      nxt_a = 8'h0F; nxt_valid = 2'b01;
      run_until(1, 80);
      expect_eq("after_cont_err", seen_err[0], 0);
      expect_eq("after_cont_rx", seen_rx[0], 8'h0F);

      // reset in the middle of SHIFT
      clear_track();
      base = n_acc;
      nxt_a = 8'h5A; nxt_valid = 2'b01;
      for (int k = 0; k < 20 && n_acc == base; k++) cyc_step();
      expect_eq("midrst_accepted", n_acc, base + 1);
      repeat (9) cyc_step();
      @(posedge clk);
      #3 rst_n = 1'b0;
      nxt_rst = 1'b0;
      model_reset();
      #1;
      expect_eq("midrst_io_t_async", bus.io_t, 1);
      expect_eq("midrst_busy_async", bus.busy, 0);
      repeat (2) cyc_step();
      nxt_rst = 1'b1;
      repeat (3) cyc_step();
      expect_eq("midrst_no_done", n_done_seen, 0);
      nxt_a = 8'hC7; nxt_valid = 2'b01;
      run_until(1, 80);
      expect_eq("midrst_next_rx", seen_rx[0], 8'hC7);
      expect_eq("midrst_next_err", seen_err[0], 0);

      // round-robin pointer
      drop_all = 1'b1;
      clear_track(); nxt_b = 8'h11; nxt_valid = 2'b10; run_until(1, 80);
      clear_track(); nxt_a = 8'h22; nxt_b = 8'h33; nxt_valid = 2'b11; run_until(1, 80);
      expect_eq("rr_after_b", seen_id[0], 0);
      clear_track(); nxt_a = 8'h44; nxt_valid = 2'b01; run_until(1, 80);
      clear_track(); nxt_a = 8'h55; nxt_b = 8'h66; nxt_valid = 2'b11; run_until(1, 80);
      expect_eq("rr_after_a", seen_id[0], 1);
      expect_eq("rr_after_a_rx", seen_rx[0], 8'h66);
      drop_all = 1'b0;

      // randomized traffic with occasional contention
      auto_drop = 1'b0;
      base = n_acc;
      for (int k = 0; k < 4000; k++) begin
         if (!m_act && $urandom_range(0, 7) == 0) nxt_force = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0) nxt_valid = 2'($urandom);
         nxt_a = W'($urandom);
         nxt_b = W'($urandom);
         cyc_step();
      end
      expect_eq("rand_made_progress", n_acc > base + 20, 1);
      nxt_force = 1'b0;
      nxt_valid = 2'b00;
      repeat (LEN + 4) cyc_step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
